// File: rtl/alu_pkg.sv
`default_nettype none
// ============================================================================
// alu_pkg : shared types and constants for the ALU arbiter slice
// Revision 1.0
// ============================================================================
package alu_pkg;

    localparam int ALU_OP_W = 18;
    localparam int ALU_DW   = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef logic id_t;

    function automatic id_t other_id(input id_t id);
        return ~id;
    endfunction

endpackage
`default_nettype wire

// File: rtl/alu_arbiter_if.sv
`default_nettype none
// ============================================================================
// alu_arbiter_if : request and response channels between issue logic and arbiter
// Revision 1.0
// ============================================================================
interface alu_arbiter_if #(
    parameter int OP_W = 18,
    parameter int DW   = 32
);
    import alu_pkg::*;

    logic [1:0]      req_valid;
    logic [1:0]      req_ready;
    logic [OP_W-1:0] req_op0;
    logic [OP_W-1:0] req_op1;
    logic [DW-1:0]   req_a0;
    logic [DW-1:0]   req_a1;
    logic [DW-1:0]   req_b0;
    logic [DW-1:0]   req_b1;
    logic            rsp_valid;
    logic            rsp_ready;
    id_t             rsp_id;
    logic [DW-1:0]   rsp_data;

    modport master (
        output req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_data
    );

    modport slave (
        input  req_valid, req_op0, req_op1, req_a0, req_a1, req_b0, req_b1, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_data
    );

endinterface
`default_nettype wire

// File: rtl/alu_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
// rr_arb2 : two-input round-robin grant with a one-bit priority pointer
// Revision 1.0
// ============================================================================
module rr_arb2
    import alu_pkg::*;
(
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic [1:0] req,
    input  wire logic       update,
    output logic      [1:0] grant,
    output id_t             grant_id
);

    id_t r_prio;

    // The pointer only matters on a tie; a lone requester always wins.
    always_comb begin
        grant_id = r_prio;
        case (req)
            2'b01:   grant_id = 1'b0;
            2'b10:   grant_id = 1'b1;
            default: grant_id = r_prio;
        endcase
    end

    assign grant = (req == 2'b00) ? 2'b00 : (grant_id ? 2'b10 : 2'b01);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_prio <= 1'b0;
        end else if (update && (req != 2'b00)) begin
            r_prio <= other_id(grant_id);
        end
    end

endmodule
`default_nettype wire

// File: rtl/alu_arbiter.sv
`default_nettype none
// ============================================================================
// alu_arbiter : shares one combinational ALU between two requesters
// Revision 1.0
// ============================================================================
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int ALU_LAT = 1,
    parameter int OP_W    = ALU_OP_W,
    parameter int DW      = ALU_DW
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    alu_arbiter_if.slave         bus,
    output logic      [OP_W-1:0] alu_op,
    output logic      [DW-1:0]   alu_in1,
    output logic      [DW-1:0]   alu_in2,
    input  wire logic [DW-1:0]   alu_out,
    output logic                 busy,
    output logic      [15:0]     done_cnt
);

    localparam logic [3:0] c_lat_init = 4'(ALU_LAT - 1);

    state_t          r_state;
    logic [3:0]      r_lat_cnt;
    id_t             r_id;
    logic [OP_W-1:0] r_alu_op;
    logic [DW-1:0]   r_alu_in1;
    logic [DW-1:0]   r_alu_in2;
    logic [DW-1:0]   r_rsp_data;
    logic            r_rsp_valid;
    logic            r_busy;
    logic [15:0]     r_done_cnt;

    logic [1:0]      w_grant;
    id_t             w_grant_id;
    logic            w_accept;
    logic [OP_W-1:0] w_sel_op;
    logic [DW-1:0]   w_sel_a;
    logic [DW-1:0]   w_sel_b;

    assign w_accept = (r_state == ST_IDLE) && (bus.req_valid != 2'b00);

    rr_arb2 u_arb (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (bus.req_valid),
        .update   (w_accept),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    // Gated by rst_n so no requester sees an accept while reset is held.
    assign bus.req_ready = (rst_n && (r_state == ST_IDLE)) ? w_grant : 2'b00;

    assign w_sel_op = w_grant_id ? bus.req_op1 : bus.req_op0;
    assign w_sel_a  = w_grant_id ? bus.req_a1  : bus.req_a0;
    assign w_sel_b  = w_grant_id ? bus.req_b1  : bus.req_b0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_lat_cnt   <= 4'd0;
            r_id        <= 1'b0;
            r_alu_op    <= '0;
            r_alu_in1   <= '0;
            r_alu_in2   <= '0;
            r_rsp_data  <= '0;
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_done_cnt  <= 16'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_alu_op  <= w_sel_op;
                        r_alu_in1 <= w_sel_a;
                        r_alu_in2 <= w_sel_b;
                        r_id      <= w_grant_id;
                        r_lat_cnt <= c_lat_init;
                        r_busy    <= 1'b1;
                        r_state   <= ST_EXEC;
                    end
                end
                ST_EXEC: begin
                    if (r_lat_cnt == 4'd0) begin
                        r_rsp_data  <= alu_out;
                        r_rsp_valid <= 1'b1;
                        r_state     <= ST_RESP;
                    end else begin
                        r_lat_cnt <= r_lat_cnt - 4'd1;
                    end
                end
                ST_RESP: begin
                    if (bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_busy      <= 1'b0;
                        r_done_cnt  <= r_done_cnt + 16'd1;
                        r_state     <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign alu_op        = r_alu_op;
    assign alu_in1       = r_alu_in1;
    assign alu_in2       = r_alu_in2;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_id    = r_id;
    assign bus.rsp_data  = r_rsp_data;
    assign busy          = r_busy;
    assign done_cnt      = r_done_cnt;

endmodule
`default_nettype wire

// File: tb/tb_alu_arbiter.sv
`default_nettype none
// ============================================================================
// tb_alu_arbiter : scoreboard bench for alu_arbiter (ALU_LAT=1 and ALU_LAT=4)
// Revision 1.0
// ============================================================================
module tb_alu_arbiter;
    import alu_pkg::*;

    typedef struct packed {
        id_t         id;
        logic [31:0] data;
    } rsp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1_n, rst4_n;
    int   cyc = 0;
    always @(posedge clk) cyc++;

    alu_arbiter_if #(.OP_W(ALU_OP_W), .DW(ALU_DW)) bus1 ();
    alu_arbiter_if #(.OP_W(ALU_OP_W), .DW(ALU_DW)) bus4 ();

    logic [17:0] op_1, op_4;
    logic [31:0] in1_1, in2_1, in1_4, in2_4, out_1, out_4, alu4_drive;
    logic        busy1, busy4;
    logic [15:0] done1, done4;

    // Stand-in for the shared ALU: low opcode bits pick the function,
    // odd parity of the upper bits inverts the result.
    function automatic logic [31:0] alu_model(input logic [17:0] op, input logic [31:0] a, b);
        logic [31:0] r;
        case (op[1:0])
            2'b00:   r = a & b;
            2'b01:   r = a + b;
            2'b10:   r = a ^ b;
            default: r = a - b;
        endcase
        return (^op[17:2]) ? ~r : r;
    endfunction

    assign out_1 = alu_model(op_1, in1_1, in2_1);
    assign out_4 = alu4_drive;

    alu_arbiter #(.ALU_LAT(1)) dut1 (
        .clk(clk), .rst_n(rst1_n), .bus(bus1.slave),
        .alu_op(op_1), .alu_in1(in1_1), .alu_in2(in2_1), .alu_out(out_1),
        .busy(busy1), .done_cnt(done1)
    );

    alu_arbiter #(.ALU_LAT(4)) dut4 (
        .clk(clk), .rst_n(rst4_n), .bus(bus4.slave),
        .alu_op(op_4), .alu_in1(in1_4), .alu_in2(in2_4), .alu_out(out_4),
        .busy(busy4), .done_cnt(done4)
    );

    int   n_chk = 0;
    int   n_pass = 0;
    rsp_t q1[$];
    rsp_t q4[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Monitors: compare every presented response against the queue head,
    // so stalled responses are checked for stability each cycle.
    logic        pend1 = 1'b0;
    logic [15:0] next_done1;
    always @(negedge clk) begin
        if (pend1) begin
            check("done_cnt_incr", done1, next_done1);
            pend1 = 1'b0;
        end
        if (rst1_n && bus1.rsp_valid) begin
            if (q1.size() == 0) begin
                check("rsp1_unexpected", 1, 0);
            end else begin
                check("rsp1_id", bus1.rsp_id, q1[0].id);
                check("rsp1_data", bus1.rsp_data, q1[0].data);
                if (bus1.rsp_ready) begin
                    void'(q1.pop_front());
                    next_done1 = done1 + 16'd1;
                    pend1      = 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (rst4_n && bus4.rsp_valid) begin
            if (q4.size() == 0) begin
                check("rsp4_unexpected", 1, 0);
            end else begin
                check("rsp4_id", bus4.rsp_id, q4[0].id);
                check("rsp4_data", bus4.rsp_data, q4[0].data);
                if (bus4.rsp_ready) void'(q4.pop_front());
            end
        end
    end

    task automatic drive_after_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req1(input int who, input logic [17:0] op, input logic [31:0] a, b);
        if (who == 0) begin
            bus1.req_op0 = op; bus1.req_a0 = a; bus1.req_b0 = b;
        end else begin
            bus1.req_op1 = op; bus1.req_a1 = a; bus1.req_b1 = b;
        end
    endtask

    task automatic send1(input int who, input logic [17:0] op, input logic [31:0] a, b,
                         input logic [31:0] exp, input bit push);
        bit got = 1'b0;
        set_req1(who, op, a, b);
        bus1.req_valid[who] = 1'b1;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus1.req_ready[who]) begin
                got = 1'b1;
                break;
            end
        end
        check("accept_seen", got, 1);
        check("grant_onehot", bus1.req_ready, (who == 1) ? 2'b10 : 2'b01);
        if (push) q1.push_back({1'(who), exp});
        drive_after_edge();
        bus1.req_valid[who] = 1'b0;
        check("alu_op_latch", op_1, op);
        check("alu_in1_latch", in1_1, a);
        check("alu_in2_latch", in2_1, b);
        check("busy_exec", busy1, 1);
        check("ready_exec", bus1.req_ready, 2'b00);
    endtask

    task automatic drain1();
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (q1.size() == 0 && !bus1.rsp_valid) break;
        end
        check("drain1", q1.size(), 0);
    endtask

    initial begin
        bit got;
        int t_last;
        rst1_n = 1'b0; rst4_n = 1'b0;
        bus1.req_valid = 2'b11; bus1.rsp_ready = 1'b1;
        bus4.req_valid = 2'b11; bus4.rsp_ready = 1'b1;
        set_req1(0, 18'h0, 32'h0, 32'h0);
        set_req1(1, 18'h0, 32'h0, 32'h0);
        bus4.req_op0 = '0; bus4.req_a0 = '0; bus4.req_b0 = '0;
        bus4.req_op1 = '0; bus4.req_a1 = '0; bus4.req_b1 = '0;
        alu4_drive = 32'hDEAD0000;
        t_last = 0;

        // Reset values, with both requests asserted during reset
        repeat (2) @(negedge clk);
        check("rst_ready1", bus1.req_ready, 2'b00);
        check("rst_ready4", bus4.req_ready, 2'b00);
        check("rst_rsp_valid", bus1.rsp_valid, 0);
        check("rst_rsp_id", bus1.rsp_id, 0);
        check("rst_rsp_data", bus1.rsp_data, 0);
        check("rst_alu_op", op_1, 0);
        check("rst_alu_in1", in1_1, 0);
        check("rst_alu_in2", in2_1, 0);
        check("rst_busy", busy1, 0);
        check("rst_done", done1, 0);
        drive_after_edge();
        bus1.req_valid = 2'b00; bus4.req_valid = 2'b00;
        rst1_n = 1'b1; rst4_n = 1'b1;

        // Single request: add with odd upper parity -> ~(4+0x10)
        drive_after_edge();
        send1(0, 18'h10001, 32'h4, 32'h10, 32'hFFFF_FFEB, 1'b1);
        @(negedge clk);
        check("lat1_exec_no_valid", bus1.rsp_valid, 0);
        @(negedge clk);
        check("lat1_resp_valid", bus1.rsp_valid, 1);
        drain1();
        check("done_after_single", done1, 16'd1);

        // Both valid: prio is 1 after the lone grant to 0, so grants go 1,0,1,0
        drive_after_edge();
        set_req1(0, 18'h00002, 32'hF0F0_0000, 32'h0FF0_0000);
        set_req1(1, 18'h00003, 32'd100, 32'd1);
        bus1.req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            got = 1'b0;
            for (int k = 0; k < 20; k++) begin
                @(negedge clk);
                if (bus1.rsp_valid) check("ready_in_resp", bus1.req_ready, 2'b00);
                if (bus1.req_ready != 2'b00) begin
                    got = 1'b1;
                    break;
                end
            end
            check("rr_accept_seen", got, 1);
            check("rr_grant", bus1.req_ready, (i % 2 == 0) ? 2'b10 : 2'b01);
            if (i > 0) check("rr_interval", cyc - t_last, 3);
            t_last = cyc;
            if (i % 2 == 0) q1.push_back({1'b1, 32'h0000_0063});
            else            q1.push_back({1'b0, 32'hFF00_0000});
        end
        drive_after_edge();
        bus1.req_valid = 2'b00;
        drain1();

        // Response stall with requester 0 pending behind it
        drive_after_edge();
        bus1.rsp_ready = 1'b0;
        send1(1, 18'h3FFFF, 32'h10, 32'h20, 32'hFFFF_FFF0, 1'b1);
        set_req1(0, 18'h00000, 32'hFFFF_0000, 32'h1234_5678);
        bus1.req_valid[0] = 1'b1;
        got = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (bus1.rsp_valid) begin
                got = 1'b1;
                break;
            end
        end
        check("stall_rsp_seen", got, 1);
        for (int s = 0; s < 5; s++) begin
            check("stall_ready", bus1.req_ready, 2'b00);
            check("stall_busy", busy1, 1);
            check("stall_valid", bus1.rsp_valid, 1);
            if (s < 4) @(negedge clk);
        end
        drive_after_edge();
        bus1.rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("b2b_grant_first_idle", bus1.req_ready, 2'b01);
        q1.push_back({1'b0, 32'h1234_0000});
        drive_after_edge();
        bus1.req_valid = 2'b00;
        drain1();

        // Reset during EXEC drops the operation and clears prio
        drive_after_edge();
        send1(0, 18'h00001, 32'd7, 32'd8, 32'd0, 1'b0);
        rst1_n = 1'b0;
        set_req1(0, 18'h00001, 32'd7, 32'd8);
        set_req1(1, 18'h00002, 32'hAAAA_5555, 32'hFFFF_0000);
        bus1.req_valid = 2'b11;
        @(negedge clk);
        check("mid_rst_valid", bus1.rsp_valid, 0);
        check("mid_rst_busy", busy1, 0);
        check("mid_rst_op", op_1, 0);
        check("mid_rst_in1", in1_1, 0);
        check("mid_rst_data", bus1.rsp_data, 0);
        check("mid_rst_done", done1, 0);
        check("mid_rst_ready", bus1.req_ready, 2'b00);
        drive_after_edge();
        rst1_n = 1'b1;
        @(negedge clk);
        check("post_rst_prio0", bus1.req_ready, 2'b01);
        q1.push_back({1'b0, 32'd15});
        drive_after_edge();
        bus1.req_valid = 2'b10;
        got = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (bus1.req_ready != 2'b00) begin
                got = 1'b1;
                break;
            end
        end
        check("post_rst_req1_seen", got, 1);
        check("post_rst_req1_grant", bus1.req_ready, 2'b10);
        q1.push_back({1'b1, 32'h5555_5555});
        drive_after_edge();
        bus1.req_valid = 2'b00;
        drain1();
        check("done_after_reset", done1, 16'd2);

        // Counter wrap, preloaded just below the top
        drive_after_edge();
        force dut1.r_done_cnt = 16'hFFFE;
        drive_after_edge();
        release dut1.r_done_cnt;
        @(negedge clk);
        check("preload_done", done1, 16'hFFFE);
        drive_after_edge();
        send1(0, 18'h00001, 32'd1, 32'd1, 32'd2, 1'b1);
        drain1();
        drive_after_edge();
        send1(1, 18'h00000, 32'hF, 32'h3, 32'h3, 1'b1);
        drain1();
        check("done_wrap", done1, 16'h0000);

        // ALU_LAT=4: only the 4th EXEC cycle's alu_out may be captured
        drive_after_edge();
        bus4.req_op1 = 18'h0002A; bus4.req_a1 = 32'h1; bus4.req_b1 = 32'h2;
        bus4.req_valid = 2'b10;
        @(negedge clk);
        check("lat4_grant", bus4.req_ready, 2'b10);
        q4.push_back({1'b1, 32'hC0FF_EE00});
        for (int j = 1; j <= 4; j++) begin
            drive_after_edge();
            if (j == 1) begin
                bus4.req_valid = 2'b00;
                check("lat4_op_latch", op_4, 18'h0002A);
                check("lat4_in1_latch", in1_4, 32'h1);
                check("lat4_in2_latch", in2_4, 32'h2);
                check("lat4_busy", busy4, 1);
            end
            alu4_drive = (j == 4) ? 32'hC0FF_EE00 : (32'hBAD0_0000 | 32'(j));
            @(negedge clk);
            check("lat4_no_early_valid", bus4.rsp_valid, 0);
        end
        drive_after_edge();
        alu4_drive = 32'hBAD0_0005;
        @(negedge clk);
        check("lat4_valid", bus4.rsp_valid, 1);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            if (q4.size() == 0 && !bus4.rsp_valid) break;
        end
        check("drain4", q4.size(), 0);
        check("lat4_done", done4, 16'd1);

        repeat (3) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
